env_grid_step: RTL
==================

// Module: env_grid_step
// PURPOSE
//  Grid-world environment stage for the DQN datapath. It sits directly upstream of the control
//  unit: it takes the control unit's controller phase (1..9) and step counter, plus an action
//  from the action selector. Once per step it applies the action to the agent position and
//  produces the next state st1, the previous state st0, the reward and the done flag.
//  st1 feeds the control unit's terminal check (st1 == GOAL_STATE).
// PARAMETERS
//  GRID_W       3   grid side; states 1..GRID_W*GRID_W, row-major; GRID_W*GRID_W <= 15
//  START_STATE  1   state loaded at reset and at each episode start
//  GOAL_STATE   9   terminal state; entering it asserts done
//  ACT_PHASE    4   controller value at which the action is sampled; legal range 2..8
//  REWARD_GOAL  10  reward on entering GOAL_STATE
//  REWARD_WALL  5   penalty magnitude on a wall bump (reward = -REWARD_WALL)
//  REWARD_STEP  1   penalty magnitude on a normal move (reward = -REWARD_STEP)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  controller     in   4   phase from control unit (1..9; 0 right after reset)
//  step           in   4   step index from control unit (1..15; 0 right after reset)
//  action         in   2   0=up 1=down 2=left 3=right
//  action_valid   in   1   action is valid this cycle
//  st1            out  4   current state (1..GRID_W*GRID_W)
//  st0            out  4   state before the last transition
//  reward         out  8   signed reward of the last transition
//  done           out  1   st1 == GOAL_STATE
//  env_valid      out  1   one-cycle pulse when st1/st0/reward update
//  stall          out  1   one-cycle pulse when action_valid was low at ACT_PHASE
//  ep_return      out  12  signed sum of rewards in the current episode, saturating
//  episode_count  out  12  number of episode starts, wraps at 4095 -> 0
// BEHAVIOUR
//  - Reset: row/col = position of START_STATE. st1 = st0 = START_STATE; reward = 0;
//    done = 0 (1 if START_STATE == GOAL_STATE); env_valid = stall = 0;
//    ep_return = 0; episode_count = 0. Reset overrides all other events, including mid-step.
//  - Position is held as row/col registers. st1 = row*GRID_W + col + 1, combinational from
//    those registers. done is combinational: (st1 == GOAL_STATE).
//  - Sample condition: controller == ACT_PHASE, done == 0 and action_valid == 1. On the
//    following edge the block updates:
//    - row/col move one cell; up = row-1, down = row+1, left = col-1, right = col+1.
//    - st0 <= old st1.
//    - reward <= +REWARD_GOAL if the new state is GOAL_STATE; else -REWARD_WALL if the move
//      would leave the grid (position unchanged); else -REWARD_STEP.
//    - env_valid pulses for exactly the cycle after the sample edge. Latency: st1 is valid
//      at controller == ACT_PHASE+1, well before the control unit samples it at phase 9.
//  - Stall: at ACT_PHASE with done == 0 and action_valid == 0, the position holds,
//    st0 <= st1, reward <= 0, and env_valid and stall both pulse for one cycle.
//  - While done == 1: ACT_PHASE events are ignored (no move, no pulses); st1 stays at
//    GOAL_STATE until the next episode start.
//  - Episode start: controller == 1 and step == 1. This covers the control unit restarting
//    after a terminal state or after the step 15 timeout. On that edge:
//    - row/col <= START_STATE; st0 <= START_STATE; reward <= 0;
//    - ep_return <= 0; episode_count += 1.
//    No env_valid pulse. Because ACT_PHASE >= 2, an episode start never coincides with a
//    sample.
//  - ep_return += reward on every env_valid update, saturating at +2047 / -2048.
//  - action_valid outside ACT_PHASE is ignored. controller values > 9 are ignored.
// TESTING
//  1 Reset, then hold rst 2 cycles -> st1=1, st0=1, reward=0, done=0, env_valid=0, counters 0.
//  2 First episode start (step=1, ctrl=1) -> episode_count=1; at ctrl=4 action=3 (right)
//    -> st1=2, st0=1, reward=-1, env_valid 1 cycle at ctrl=5.
//  3 From state 1, action=0 (up) -> st1=1, reward=-5, ep_return=-5.
//  4 Actions right,right,down,down over 4 steps -> st1 sequence 2,3,6,9; last reward=+10;
//    done=1; ep_return=7. A further ACT_PHASE with a valid action -> no change, no pulse.
//  5 action_valid=0 at ACT_PHASE -> stall and env_valid pulse; reward=0; st1 unchanged.
//    Next episode start (step=1, ctrl=1) after done -> st1=1, done=0, ep_return=0,
//    episode_count incremented.
//  6 Assert rst at ctrl=4 while action_valid=1, in state 6 -> st1=1, no env_valid, all
//    outputs at reset values.

Source files
------------

// File: rtl/env_grid_step.sv
// Grid-world environment stage: moves the agent one cell per controller step and
// reports next/previous state, reward, done and per-episode statistics.
module env_grid_step #(
  parameter int GRID_W      = 3,
  parameter int START_STATE = 1,
  parameter int GOAL_STATE  = 9,
  parameter int ACT_PHASE   = 4,
  parameter int REWARD_GOAL = 10,
  parameter int REWARD_WALL = 5,
  parameter int REWARD_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  controller,
  input  logic [3:0]  step,
  input  logic [1:0]  action,
  input  logic        action_valid,
  output logic [3:0]  st1,
  output logic [3:0]  st0,
  output logic [7:0]  reward,
  output logic        done,
  output logic        env_valid,
  output logic        stall,
  output logic [11:0] ep_return,
  output logic [11:0] episode_count
);

  localparam logic [3:0] GW        = 4'(GRID_W);
  localparam logic [3:0] LAST      = 4'(GRID_W - 1);
  localparam logic [3:0] START_ROW = 4'((START_STATE - 1) / GRID_W);
  localparam logic [3:0] START_COL = 4'((START_STATE - 1) % GRID_W);
  localparam logic [3:0] START_ST  = 4'(START_STATE);
  localparam logic [3:0] GOAL_ST   = 4'(GOAL_STATE);
  localparam logic [3:0] ACT_PH    = 4'(ACT_PHASE);
  localparam logic [7:0] R_GOAL    = 8'(REWARD_GOAL);
  localparam logic [7:0] R_WALL    = 8'(-REWARD_WALL);
  localparam logic [7:0] R_STEP    = 8'(-REWARD_STEP);

  logic [3:0]  row, col;
  logic [3:0]  row_n, col_n;
  logic [3:0]  st_n;
  logic        wall;
  logic [7:0]  rew_n;
  logic [12:0] acc;
  logic [11:0] ret_sat;
  logic        ep_start, sample;

  assign st1      = row * GW + col + 4'd1;
  assign done     = (st1 == GOAL_ST);
  assign ep_start = (controller == 4'd1) && (step == 4'd1);
  assign sample   = (controller == ACT_PH) && !done;

  always_comb begin
    row_n = row;
    col_n = col;
    wall  = 1'b0;
    case (action)
      2'd0: if (row == 4'd0) wall = 1'b1; else row_n = row - 4'd1;
      2'd1: if (row == LAST) wall = 1'b1; else row_n = row + 4'd1;
      2'd2: if (col == 4'd0) wall = 1'b1; else col_n = col - 4'd1;
      default: if (col == LAST) wall = 1'b1; else col_n = col + 4'd1;
    endcase
    st_n = row_n * GW + col_n + 4'd1;
    if (wall)                 rew_n = R_WALL;
    else if (st_n == GOAL_ST) rew_n = R_GOAL;
    else                      rew_n = R_STEP;
  end

  // Sign-extended add with clamp to the 12-bit signed range.
  always_comb begin
    acc = {ep_return[11], ep_return} + {{5{rew_n[7]}}, rew_n};
    case (acc[12:11])
      2'b01:   ret_sat = 12'h7FF;
      2'b10:   ret_sat = 12'h800;
      default: ret_sat = acc[11:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row           <= START_ROW;
      col           <= START_COL;
      st0           <= START_ST;
      reward        <= 8'd0;
      env_valid     <= 1'b0;
      stall         <= 1'b0;
      ep_return     <= 12'd0;
      episode_count <= 12'd0;
    end else begin
      env_valid <= 1'b0;
      stall     <= 1'b0;
      if (ep_start) begin
        row           <= START_ROW;
        col           <= START_COL;
        st0           <= START_ST;
        reward        <= 8'd0;
        ep_return     <= 12'd0;
        episode_count <= episode_count + 12'd1;
      end else if (sample) begin
        st0       <= st1;
        env_valid <= 1'b1;
        if (action_valid) begin
          row       <= row_n;
          col       <= col_n;
          reward    <= rew_n;
          ep_return <= ret_sat;
        end else begin
          reward <= 8'd0;
          stall  <= 1'b1;
        end
      end
    end
  end

endmodule
